// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests a word, holds it until the datapath commits,
// then steers the PC (sequential, branch, jump, jump-register) or stops on halt.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        commit,
   input  logic        Branch,
   input  logic        zero,
   input  logic [1:0]  JmpSel,
   input  logic [31:0] jr_addr,
   input  logic        halt,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] count_q, count_d;
   logic        instr_valid_q, instr_valid_d;
   logic        halted_q, halted_d;
   logic [31:0] br_off;
   logic [31:0] next_pc;

   assign pc_plus4 = pc_q + 32'd4;
   assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // Jumps win over branches; JmpSel=11 falls through to the sequential/branch path.
   always_comb begin
      next_pc = pc_plus4;
      if (JmpSel == 2'b01)
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      else if (JmpSel == 2'b10)
         next_pc = jr_addr;
      else if (Branch && zero)
         next_pc = pc_plus4 + br_off;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      count_d       = count_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
      case (state_q)
         FETCH: begin
            if (ihit) begin
               instr_d       = imemload;
               instr_valid_d = 1'b1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            if (commit) begin
               instr_valid_d = 1'b0;
               count_d       = count_q + 32'd1;
               if (halt) begin
                  halted_d = 1'b1;
                  state_d  = HALTED;
               end else begin
                  pc_d    = next_pc;
                  state_d = FETCH;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q       <= FETCH;
         pc_q          <= PC_INIT;
         instr_q       <= 32'd0;
         count_q       <= 32'd0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         count_q       <= count_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
      end
   end

   assign imemREN     = (state_q == FETCH);
   assign imemaddr    = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a PC-steering vector table and
// randomized fetch/commit transactions checked against a transaction-level model.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        nRST, ihit, commit, Branch, zero, halt;
   logic [31:0] imemload, jr_addr;
   logic [1:0]  JmpSel;
   logic        imemREN, instr_valid, halted;
   logic [31:0] imemaddr, instr, pc_plus4, instr_count;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_unit dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .commit(commit),
      .Branch(Branch), .zero(zero), .JmpSel(JmpSel), .jr_addr(jr_addr), .halt(halt),
      .imemREN(imemREN), .imemaddr(imemaddr), .instr(instr), .instr_valid(instr_valid),
      .pc_plus4(pc_plus4), .halted(halted), .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] start;
      logic [31:0] ins;
      logic [31:0] jr;
      logic [1:0]  js;
      logic        br;
      logic        z;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
   endtask

   task automatic fetch_word(input logic [31:0] w);
      ihit = 1'b1;
      imemload = w;
      tick();
      ihit = 1'b0;
   endtask

   task automatic commit_op(input logic br, input logic z, input logic [1:0] js,
                            input logic [31:0] jr, input logic h);
      Branch = br; zero = z; JmpSel = js; jr_addr = jr; halt = h; commit = 1'b1;
      tick();
      Branch = 1'b0; zero = 1'b0; JmpSel = 2'b00; jr_addr = 32'd0; halt = 1'b0; commit = 1'b0;
   endtask

   // Steer the PC anywhere with a jump-register commit.
   task automatic goto_pc(input logic [31:0] pc);
      fetch_word(32'd0);
      commit_op(1'b0, 1'b0, 2'b10, pc, 1'b0);
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic [31:0] jr, input logic [1:0] js,
                                            input logic br, input logic z);
      logic [31:0] p4;
      int          off;
      p4 = pc + 32'd4;
      if (js == 2'b01) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      if (js == 2'b10) return jr;
      if (br && z) begin
         off = $signed(ins[15:0]);
         return p4 + 32'(off * 4);
      end
      return p4;
   endfunction

   initial begin
      logic [31:0] pc_m, cnt_m, w;
      logic [31:0] r_jr;
      logic [1:0]  r_js;
      logic        r_br, r_z, r_h;

      tbl[0] = '{32'h0000_0000, 32'h2001_0005, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0000_0004};
      tbl[1] = '{32'h0000_0010, 32'h1000_FFFE, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0000_000C};
      tbl[2] = '{32'h0000_0010, 32'h1000_FFFE, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0000_0014};
      tbl[3] = '{32'h4000_0000, 32'h0800_0100, 32'h0, 2'b01, 1'b1, 1'b1, 32'h4000_0400};
      tbl[4] = '{32'h4000_0000, 32'h0800_0100, 32'h0000_0ABC, 2'b10, 1'b1, 1'b1, 32'h0000_0ABC};
      tbl[5] = '{32'h0000_0100, 32'h0000_0003, 32'h0, 2'b11, 1'b1, 1'b1, 32'h0000_0110};
      tbl[6] = '{32'hFFFF_FFFC, 32'h2001_0005, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0000_0000};
      tbl[7] = '{32'hEFFF_FFFC, 32'h0BFF_FFFF, 32'h0, 2'b01, 1'b0, 1'b0, 32'hFFFF_FFFC};
      tbl[8] = '{32'hFFFF_FFF8, 32'h0000_0001, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0000_0000};
      tbl[9] = '{32'h0000_0020, 32'h0000_0000, 32'h0000_0123, 2'b10, 1'b0, 1'b0, 32'h0000_0123};

      nRST = 1'b0; ihit = 1'b0; commit = 1'b0; Branch = 1'b0; zero = 1'b0; halt = 1'b0;
      imemload = 32'd0; jr_addr = 32'd0; JmpSel = 2'b00;
      #1;
      // Reset holds even with activity on the inputs.
      ihit = 1'b1; commit = 1'b1; imemload = 32'hDEAD_BEEF;
      tick(); tick();
      check("rst_imemREN", 32'(imemREN), 32'd1);
      check("rst_imemaddr", imemaddr, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_count", instr_count, 32'd0);
      check("rst_pc_plus4", pc_plus4, 32'd4);
      ihit = 1'b0; commit = 1'b0; imemload = 32'd0;
      nRST = 1'b1;

      // Sequential fetch and latency.
      ihit = 1'b1; imemload = 32'h2001_0005;
      check("lat_pre_valid", 32'(instr_valid), 32'd0);
      tick();
      ihit = 1'b0;
      check("lat_valid", 32'(instr_valid), 32'd1);
      check("lat_instr", instr, 32'h2001_0005);
      check("hold_imemREN", 32'(imemREN), 32'd0);
      commit_op(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
      check("seq_pc", imemaddr, 32'd4);
      check("seq_count", instr_count, 32'd1);
      check("seq_valid", 32'(instr_valid), 32'd0);
      check("seq_imemREN", 32'(imemREN), 32'd1);

      // Commit while fetching is ignored.
      commit_op(1'b0, 1'b0, 2'b10, 32'h0000_0800, 1'b1);
      check("fetch_commit_pc", imemaddr, 32'd4);
      check("fetch_commit_cnt", instr_count, 32'd1);
      check("fetch_commit_halt", 32'(halted), 32'd0);

      // Five-cycle stall.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_pc", imemaddr, 32'd4);
         check("stall_valid", 32'(instr_valid), 32'd0);
      end

      // ihit pulses during HOLD do not disturb the held word.
      fetch_word(32'hAAAA_0001);
      ihit = 1'b1; imemload = 32'h5555_5555;
      tick();
      ihit = 1'b0;
      check("hold_ihit_instr", instr, 32'hAAAA_0001);

      // Halt without commit does nothing.
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("halt_nc_halted", 32'(halted), 32'd0);
      check("halt_nc_valid", 32'(instr_valid), 32'd1);
      check("halt_nc_pc", imemaddr, 32'd4);

      // Halt with commit freezes; jump request alongside must not move PC.
      commit_op(1'b0, 1'b0, 2'b10, 32'h0000_0800, 1'b1);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_pc", imemaddr, 32'd4);
      check("halt_count", instr_count, 32'd2);
      check("halt_imemREN", 32'(imemREN), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
      ihit = 1'b1; commit = 1'b1; imemload = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("halted_pc", imemaddr, 32'd4);
         check("halted_count", instr_count, 32'd2);
         check("halted_instr", instr, 32'hAAAA_0001);
         check("halted_imemREN", 32'(imemREN), 32'd0);
      end
      ihit = 1'b0; commit = 1'b0;
      do_reset();
      check("unhalt_halted", 32'(halted), 32'd0);
      check("unhalt_imemREN", 32'(imemREN), 32'd1);
      check("unhalt_count", instr_count, 32'd0);

      // PC steering table.
      foreach (tbl[i]) begin
         do_reset();
         goto_pc(tbl[i].start);
         check("tbl_start", imemaddr, tbl[i].start);
         fetch_word(tbl[i].ins);
         check("tbl_pc_plus4", pc_plus4, tbl[i].start + 32'd4);
         commit_op(tbl[i].br, tbl[i].z, tbl[i].js, tbl[i].jr, 1'b0);
         check($sformatf("tbl%0d_next_pc", i), imemaddr, tbl[i].exp);
         check("tbl_count", instr_count, 32'd2);
      end

      // Reset mid-HOLD beats a same-edge commit.
      do_reset();
      goto_pc(32'h0000_0040);
      fetch_word(32'h2001_0005);
      nRST = 1'b0; commit = 1'b1; ihit = 1'b1;
      tick();
      nRST = 1'b1; commit = 1'b0; ihit = 1'b0;
      check("rst_hold_pc", imemaddr, 32'd0);
      check("rst_hold_count", instr_count, 32'd0);
      check("rst_hold_valid", 32'(instr_valid), 32'd0);
      check("rst_hold_instr", instr, 32'd0);
      check("rst_hold_imemREN", 32'(imemREN), 32'd1);

      // Randomized transactions.
      do_reset();
      pc_m = 32'd0; cnt_m = 32'd0;
      for (int t = 0; t < 150; t++) begin
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            tick();
            check("rnd_stall_pc", imemaddr, pc_m);
            check("rnd_stall_valid", 32'(instr_valid), 32'd0);
         end
         w = $urandom;
         if ($urandom_range(0, 1) == 0) w[31:16] = 16'h1000;
         fetch_word(w);
         check("rnd_instr", instr, w);
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            ihit = $urandom_range(0, 1); imemload = ~w; halt = $urandom_range(0, 1);
            tick();
            ihit = 1'b0; halt = 1'b0;
            check("rnd_hold_instr", instr, w);
            check("rnd_hold_pc", imemaddr, pc_m);
         end
         r_br = $urandom_range(0, 1); r_z = $urandom_range(0, 1);
         r_js = $urandom_range(0, 3); r_jr = $urandom;
         r_h  = ($urandom_range(0, 15) == 0);
         commit_op(r_br, r_z, r_js, r_jr, r_h);
         cnt_m = cnt_m + 32'd1;
         check("rnd_count", instr_count, cnt_m);
         if (r_h) begin
            check("rnd_halt_pc", imemaddr, pc_m);
            check("rnd_halted", 32'(halted), 32'd1);
            do_reset();
            pc_m = 32'd0; cnt_m = 32'd0;
         end else begin
            pc_m = ref_next(pc_m, w, r_jr, r_js, r_br, r_z);
            check("rnd_next_pc", imemaddr, pc_m);
            check("rnd_imemREN", 32'(imemREN), 32'd1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_INIT, default 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, synchronous and active-low.
REQ-004 ihit  in  1  instruction memory hit; imemload valid this cycle.
REQ-005 imemload  in  32  instruction word from instruction memory.
REQ-006 commit  in  1  one-cycle pulse from datapath: held instruction finished (incl. any dhit).
REQ-007 Branch  in  1  branch instruction, from control unit.
REQ-008 zero  in  1  ALU zero flag for held instruction.
REQ-009 JmpSel  in  2  next-PC select from control unit: 00 seq, 01 jump, 10 jump-register, 11 reserved.
REQ-010 jr_addr  in  32  register rs value for jump-register.
REQ-011 halt  in  1  halt decoded for held instruction.
REQ-012 imemREN  out  1  instruction read request.
REQ-013 imemaddr  out  32  instruction address, equals current PC.
REQ-014 instr  out  32  latched instruction word, drives control unit imemLoad.
REQ-015 instr_valid  out  1  instr holds a fetched, uncommitted instruction.
REQ-016 pc_plus4  out  32  PC+4, for JAL link value.
REQ-017 halted  out  1  fetch permanently stopped.
REQ-018 instr_count  out  32  retired-instruction counter.

Function
REQ-019 States: FETCH, HOLD, HALTED; reset state FETCH.
REQ-020 FETCH: imemREN=1; on ihit -> instr<=imemload, instr_valid<=1, go HOLD next edge; no ihit -> stay, PC unchanged.
REQ-021 HOLD: imemREN=0; ihit ignored; instr and PC held until commit.
REQ-022 HOLD with commit and halt=0: PC<=next_pc, instr_valid<=0, instr_count+=1, go FETCH.
REQ-023 HOLD with commit and halt=1: PC unchanged, instr_valid<=0, instr_count+=1, halted<=1, go HALTED.
REQ-024 halt without commit has no effect; commit in FETCH or HALTED ignored.
REQ-025 HALTED: imemREN=0, all state frozen until reset.
REQ-026 pc_plus4 = PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-027 next_pc: JmpSel=01 -> {pc_plus4[31:28], instr[25:0], 2'b00}; JmpSel=10 -> jr_addr; else Branch&zero -> pc_plus4 + (sign-extended instr[15:0] << 2), mod 2^32; else pc_plus4.
REQ-028 JmpSel 01/10 take priority over Branch; JmpSel=11 treated as 00.
REQ-029 jr_addr used unmodified; no alignment check.
REQ-030 instr_count wraps from 32'hFFFF_FFFF to 0.
REQ-031 Fetch latency: instr_valid rises the edge after the first ihit cycle in FETCH; next request one cycle after commit.

Reset
REQ-032 nRST low at rising edge: PC<=PC_INIT, state<=FETCH, instr<=0, instr_valid<=0, halted<=0, instr_count<=0.
REQ-033 Reset overrides ihit, commit and halt at the same edge, in any state, including mid-HOLD and HALTED.
REQ-034 Outputs during reset cycle after edge: imemREN=1, imemaddr=PC_INIT.

Verification
REQ-035 Sequential: reset, ihit with imemload=32'h2001_0005, commit, Branch=0, JmpSel=00 -> imemaddr 0 -> 4, instr_count=1.
REQ-036 Taken branch: PC=32'h10, instr[15:0]=16'hFFFE, Branch=1, zero=1, commit -> PC=32'h0C; zero=0 -> PC=32'h14.
REQ-037 Jump: PC=32'h4000_0000, instr[25:0]=26'h0000100, JmpSel=01, Branch=1, zero=1 -> PC=32'h4000_0400 (jump beats branch); JmpSel=10, jr_addr=32'h0000_0ABC -> PC=32'h0000_0ABC.
REQ-038 Halt: HOLD, halt=1 with commit -> halted=1, imemREN=0, PC unchanged, further ihit/commit ignored; halt=1 without commit -> no change.
REQ-039 Stall/ignore: ihit held low 5 cycles in FETCH -> PC stable, instr_valid=0; ihit pulsed in HOLD -> instr unchanged.
REQ-040 Reset mid-HOLD with commit=1 same edge -> PC=PC_INIT, instr_count=0, state FETCH; wrap: PC=32'hFFFF_FFFC sequential -> PC=0.
